// File: rtl/spi_flash_stream_reader.sv
// spi_flash_stream_reader: windowed SPI Mode 0 flash reader with CPU stall and sequential streaming.
// Define FLASH_FAST_READ_EN to issue 0x0B fast reads with 8 dummy clocks instead of 0x03.
module spi_flash_stream_reader #(
    parameter int          ADDR_BITS   = 12,
    parameter logic [23:0] FLASH_BASE  = 24'h000000,
    parameter int          CLK_DIV     = 1,
    parameter int          STREAM_HOLD = 64,
    parameter int          CS_HIGH_MIN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_ce,
    input  logic        i_RW,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic        i_SPI_MISO,
    output logic        o_SPI_CLK,
    output logic        o_SPI_MOSI,
    output logic        o_SPI_CS,
    output logic [7:0]  o_DATA,
    output logic        o_MemoryReady
);
`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] CMD  = 8'h0B;
    localparam bit         FAST = 1'b1;
`else
    localparam logic [7:0] CMD  = 8'h03;
    localparam bit         FAST = 1'b0;
`endif
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int HOLD_W = $clog2(STREAM_HOLD + 2);
    localparam int REC_W  = $clog2(CS_HIGH_MIN + 1);
    localparam logic [15:0] WIN_MASK = 16'((32'd1 << ADDR_BITS) - 32'd1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD, S_RECOVER} state_t;

    state_t              r_state, w_next;
    logic [DIV_W-1:0]    r_div;
    logic                r_sck, r_cs, r_dvalid;
    logic [4:0]          r_bit;
    logic [31:0]         r_sh;
    logic [7:0]          r_rx, r_data;
    logic [23:0]         r_cur, r_daddr;
    logic [HOLD_W-1:0]   r_hold;
    logic [REC_W-1:0]    r_rec;

    logic [23:0] w_faddr;
    logic        w_req, w_hit, w_miss, w_consec, w_xfer, w_half, w_rise, w_bit_end, w_step;
    logic        w_hold_exp, w_rec_done;

    assign w_faddr    = FLASH_BASE + {8'd0, i_ADDRESS_BUS & WIN_MASK};
    assign w_req      = spi_ce & i_RW;
    assign w_hit      = r_dvalid & (w_faddr == r_daddr);
    assign w_miss     = w_req & ~w_hit;
    assign w_consec   = (r_daddr != 24'hFFFFFF) & (w_faddr == r_daddr + 24'd1);
    assign w_xfer     = (r_state == S_CMD) | (r_state == S_ADDR) | (r_state == S_DUMMY) | (r_state == S_DATA);
    assign w_half     = w_xfer & (r_div == DIV_W'(CLK_DIV - 1));
    assign w_rise     = w_half & ~r_sck;
    assign w_bit_end  = w_half & r_sck;
    assign w_step     = w_bit_end & (r_bit == ((r_state == S_ADDR) ? 5'd23 : 5'd7));
    assign w_hold_exp = r_hold == HOLD_W'(STREAM_HOLD > 0 ? STREAM_HOLD - 1 : 0);
    assign w_rec_done = r_rec == REC_W'(CS_HIGH_MIN - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_miss) w_next = S_CMD;
            S_CMD:     if (w_step) w_next = S_ADDR;
            S_ADDR:    if (w_step) w_next = FAST ? S_DUMMY : S_DATA;
            S_DUMMY:   if (w_step) w_next = S_DATA;
            S_DATA:    if (w_step) w_next = (STREAM_HOLD > 0) ? S_HOLD : S_RECOVER;
            // a consecutive request beats timer expiry in the same cycle
            S_HOLD:    if (w_miss & w_consec) w_next = S_DATA;
                       else if (w_miss | w_hold_exp) w_next = S_RECOVER;
            S_RECOVER: if (w_rec_done) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cs     <= 1'b1;
            r_sck    <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_sh     <= '0;
            r_rx     <= '0;
            r_data   <= '0;
            r_cur    <= '0;
            r_daddr  <= '0;
            r_dvalid <= 1'b0;
            r_hold   <= '0;
            r_rec    <= '0;
        end else begin
            r_state <= w_next;
            r_cs    <= (w_next == S_IDLE) | (w_next == S_RECOVER);
            r_div   <= (~w_xfer | w_half) ? '0 : r_div + DIV_W'(1);
            r_sck   <= w_xfer & (r_sck ^ w_half);
            r_bit   <= (~w_xfer | w_step) ? '0 : r_bit + {4'd0, w_bit_end};
            r_hold  <= (r_state == S_HOLD) ? r_hold + HOLD_W'(1) : '0;
            r_rec   <= (r_state == S_RECOVER) ? r_rec + REC_W'(1) : '0;
            if ((r_state == S_IDLE) & w_miss) begin
                r_cur <= w_faddr;
                r_sh  <= {CMD, w_faddr};
            end else if (w_bit_end) begin
                r_sh <= {r_sh[30:0], 1'b0};
            end
            if ((r_state == S_HOLD) & w_miss & w_consec)
                r_cur <= w_faddr;
            if (w_rise & (r_state == S_DATA))
                r_rx <= {r_rx[6:0], i_SPI_MISO};
            if (w_step & (r_state == S_DATA)) begin
                r_data   <= r_rx;
                r_daddr  <= r_cur;
                r_dvalid <= 1'b1;
            end
        end
    end

    assign o_SPI_CS      = r_cs;
    assign o_SPI_CLK     = r_sck;
    assign o_SPI_MOSI    = ((r_state == S_CMD) | (r_state == S_ADDR)) & r_sh[31];
    assign o_DATA        = r_data;
    assign o_MemoryReady = ~w_miss;
endmodule

// File: doc/spi_flash_stream_reader.md
# spi_flash_stream_reader

Parametrised SPI Mode 0 flash read engine between the 6809 bus decode and the boot/program serial flash. It maps a configurable CPU address window onto a 24-bit flash offset and issues READ transactions. While a read is in progress it stalls the CPU through `o_MemoryReady`. It adds a configurable SPI clock divider, last-byte hit detection, and sequential streaming: CS stays low so the next consecutive byte costs only 8 SPI clocks.

## Interface
- `ADDR_BITS`, 12: number of low CPU address bits forwarded to flash (1..16).
- `FLASH_BASE`, 24'h000000: flash offset added to the windowed CPU address.
- `CLK_DIV`, 1: system clocks per SCK half-period (≥1).
- `STREAM_HOLD`, 64: system clocks CS stays low after a byte waiting for a consecutive request; 0 disables streaming.
- `CS_HIGH_MIN`, 4: minimum system clocks CS stays high between transactions (≥1).
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `spi_ce`  in  1  decoder select for the flash window.
- `i_RW`  in  1  1 = read; writes are ignored.
- `i_ADDRESS_BUS`  in  16  CPU address.
- `i_SPI_MISO`  in  1  flash serial data out.
- `o_SPI_CLK`  out  1  SCK, idle low.
- `o_SPI_MOSI`  out  1  serial data to flash; driven 0 when idle.
- `o_SPI_CS`  out  1  active-low flash select.
- `o_DATA`  out  8  last byte read (registered).
- `o_MemoryReady`  out  1  0 = stall the CPU.

## Operation
- **Request.** `req = spi_ce & i_RW`. The flash address is `faddr = (FLASH_BASE + i_ADDRESS_BUS[ADDR_BITS-1:0]) mod 2^24`.
- **Hit.** A hit is `data_valid & (faddr == data_addr)`.
- **Ready output.** `o_MemoryReady = ~(req & ~hit)` (combinational). It is 1 for writes, for hits and when not selected.
- **States.** IDLE, CMD, ADDR, DUMMY (macro only), DATA, HOLD, RECOVER.
- **IDLE.** A miss request latches `faddr` into `cur_addr` and goes to CMD. CS falls the next cycle.
- **CMD.** Shifts 8 bits of 0x03, MSB first.
- **ADDR.** Shifts `cur_addr[23:0]`, MSB first.
- **DATA.** Shifts 8 bits of MISO in, MSB first.
- **End of byte (last falling SCK edge).** `o_DATA`←shift register, `data_addr`←`cur_addr`, `data_valid`←1. Then go to HOLD if `STREAM_HOLD>0`, else RECOVER.
- **HOLD.** CS stays low, SCK stays low, and a timer counts `STREAM_HOLD` cycles.
  - Miss request with `faddr == data_addr+1` (no carry past 24'hFFFFFF): `cur_addr`←`faddr`, back to DATA with no command or address.
  - Miss request with any other address, or timer expiry: go to RECOVER.
  - Hits do not affect the timer.
- **RECOVER.** CS high for `CS_HIGH_MIN` cycles, then IDLE. A pending miss is accepted from IDLE on the following cycle.
- **Simultaneous events.** A consecutive request in the same cycle as timer expiry streams (request wins).
- **Requests during a transfer.** Requests arriving mid-transfer (CMD/ADDR/DUMMY/DATA) are not re-latched. After completion they resolve as a hit or a new miss.
- **Address wrap.** At 24'hFFFFFF, and at the `ADDR_BITS` window edge where `faddr` is not consecutive, the next byte takes a full new transaction.
- **Reset values (async, any state).** `o_SPI_CS`=1, `o_SPI_CLK`=0, `o_SPI_MOSI`=0, `o_DATA`=0, `data_valid`=0, state IDLE. The transfer is aborted with no partial data.

## Timing
- **SCK phases.** Each bit is a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles.
- **MOSI.** Changes only at the start of a low phase (Mode 0).
- **MISO.** Sampled in the cycle SCK rises.
- **Full read.** Miss accepted at cycle T: CS low at T+1, and `o_DATA`/`o_MemoryReady` high at T+1+80·CLK_DIV.
- **Streamed byte.** Accepted in HOLD at T: ready at T+1+16·CLK_DIV.
- **Hit.** Zero-latency; no SPI activity.
- **Miss after RECOVER.** Adds `CS_HIGH_MIN`+1 cycles before CS falls.
- **Register timing.** `o_DATA` and `data_addr` update in the same cycle that ready rises.

## Configuration
- **`FLASH_FAST_READ_EN` defined:**
  - Command is 0x0B, followed by 8 dummy bits in DUMMY (MOSI 0, MISO ignored).
  - Full-read latency is 1+96·CLK_DIV cycles.
  - Streaming is unchanged (16·CLK_DIV).
- **Undefined:** command 0x03, no DUMMY state, latency as in Timing.

## Test plan
- **Basic read.** Reset, then read 0x0123 with CLK_DIV=1, FLASH_BASE=0, flash model byte 0xA5 at 0x000123 → MOSI sequence 0x03, 0x00, 0x01, 0x23; `o_MemoryReady` low for 81 cycles; `o_DATA`=0xA5.
- **Hit.** Re-read 0x0123 → `o_MemoryReady` stays 1, CS stays high, `o_DATA`=0xA5.
- **Streaming.** Read 0x0200, then 0x0201 within 64 cycles → no new command or address; ready after 17 cycles. A 66-cycle gap before the next read → CS high, then full transaction.
- **Non-consecutive in HOLD.** After 0x0200, request 0x0300 → CS high ≥4 cycles, new 0x03 transaction.
- **Reset mid-transfer.** Assert `reset` during the ADDR phase → CS=1, SCK=0, MOSI=0 immediately. The next read of the previous address is a miss.
- **Fast read.** With `FLASH_FAST_READ_EN` and CLK_DIV=2 → command 0x0B, 8 dummy clocks, ready at 193 cycles.
